// File: rtl/gs_row_op_engine.sv
// Row-pair COPY/SWAP/XOR/CLEAR engine over the dual-port row memory; 2+RD_LAT cycles per pair (2 for CLEAR).
// No backpressure: start is accepted only while idle, and every memory output is registered.
module gs_row_op_engine #(
  parameter int DAT_W  = 8,
  parameter int DAT_D  = 16,
  parameter int RD_LAT = 2,
  parameter int LEN_W  = 5,
  localparam int AW    = $clog2(DAT_D)
) (
  input  logic             clk,
  input  logic             rst_b,
  input  logic             start,
  input  logic [1:0]       mode,
  input  logic [AW-1:0]    addr_a,
  input  logic [AW-1:0]    addr_b,
  input  logic [LEN_W-1:0] len,
  output logic             busy,
  output logic             finish,
  input  logic [DAT_W-1:0] mem_dina,
  input  logic [DAT_W-1:0] mem_dinb,
  output logic [DAT_W-1:0] mem_douta,
  output logic [DAT_W-1:0] mem_doutb,
  output logic [AW-1:0]    mem_addra,
  output logic [AW-1:0]    mem_addrb,
  output logic             mem_rwa,
  output logic             mem_rwb
);

  typedef enum logic [2:0] {S_IDLE, S_ISSUE, S_WAIT, S_WR, S_DONE} state_t;

  localparam logic [1:0] M_COPY = 2'd0;
  localparam logic [1:0] M_SWAP = 2'd1;
  localparam logic [1:0] M_XOR  = 2'd2;
  localparam logic [1:0] M_CLR  = 2'd3;

  localparam int WW = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;
  localparam logic [WW-1:0] W_LAST = WW'(RD_LAT - 1);
  localparam logic [AW-1:0] A_LAST = AW'(DAT_D - 1);

  // Explicit wrap so non-power-of-two depths stay in range.
  function automatic logic [AW-1:0] wrap_inc(input logic [AW-1:0] x);
    return (x == A_LAST) ? '0 : x + 1'b1;
  endfunction

  state_t           state_q, state_d;
  logic [1:0]       mode_q, mode_d;
  logic [AW-1:0]    a_q, a_d, b_q, b_d;
  logic [LEN_W-1:0] len_q, len_d, cnt_q, cnt_d;
  logic [WW-1:0]    wcnt_q, wcnt_d;
  logic [LEN_W:0]   cnt_nx;
  logic             alias_ab;

  logic             busy_d, finish_d, rwa_d, rwb_d;
  logic [DAT_W-1:0] douta_d, doutb_d;
  logic [AW-1:0]    addra_d, addrb_d;

  assign cnt_nx   = {1'b0, cnt_q} + 1'b1;
  assign alias_ab = (a_q == b_q);

  always_comb begin
    state_d  = state_q;
    mode_d   = mode_q;
    a_d      = a_q;
    b_d      = b_q;
    len_d    = len_q;
    cnt_d    = cnt_q;
    wcnt_d   = wcnt_q;
    finish_d = 1'b0;
    rwa_d    = 1'b0;
    rwb_d    = 1'b0;
    douta_d  = '0;
    doutb_d  = '0;
    addra_d  = '0;
    addrb_d  = '0;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          mode_d = mode;
          a_d    = addr_a;
          b_d    = addr_b;
          len_d  = len;
          cnt_d  = '0;
          if (len == '0) begin
            state_d  = S_DONE;
            finish_d = 1'b1;
          end else begin
            state_d = S_ISSUE;
            addra_d = addr_a;
            addrb_d = addr_b;
          end
        end
      end
      S_ISSUE: begin
        addra_d = a_q;
        addrb_d = b_q;
        if (mode_q == M_CLR) begin
          state_d = S_WR;
          rwb_d   = 1'b1;
        end else begin
          state_d = S_WAIT;
          wcnt_d  = '0;
        end
      end
      S_WAIT: begin
        addra_d = a_q;
        addrb_d = b_q;
        if (wcnt_q == W_LAST) begin
          // Read data is valid this cycle; it becomes the registered write data for WR.
          state_d = S_WR;
          case (mode_q)
            M_COPY: begin
              rwb_d   = !alias_ab;
              doutb_d = alias_ab ? '0 : mem_dina;
            end
            M_SWAP: begin
              rwa_d   = !alias_ab;
              rwb_d   = !alias_ab;
              douta_d = alias_ab ? '0 : mem_dinb;
              doutb_d = alias_ab ? '0 : mem_dina;
            end
            M_XOR: begin
              rwb_d   = 1'b1;
              doutb_d = alias_ab ? '0 : (mem_dina ^ mem_dinb);
            end
            default: rwb_d = 1'b1;
          endcase
        end else begin
          wcnt_d = wcnt_q + 1'b1;
        end
      end
      S_WR: begin
        cnt_d = cnt_nx[LEN_W-1:0];
        a_d   = wrap_inc(a_q);
        b_d   = wrap_inc(b_q);
        if (cnt_nx < {1'b0, len_q}) begin
          state_d = S_ISSUE;
          addra_d = wrap_inc(a_q);
          addrb_d = wrap_inc(b_q);
        end else begin
          state_d  = S_DONE;
          finish_d = 1'b1;
        end
      end
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      state_q   <= S_IDLE;
      mode_q    <= '0;
      a_q       <= '0;
      b_q       <= '0;
      len_q     <= '0;
      cnt_q     <= '0;
      wcnt_q    <= '0;
      busy      <= 1'b0;
      finish    <= 1'b0;
      mem_rwa   <= 1'b0;
      mem_rwb   <= 1'b0;
      mem_douta <= '0;
      mem_doutb <= '0;
      mem_addra <= '0;
      mem_addrb <= '0;
    end else begin
      state_q   <= state_d;
      mode_q    <= mode_d;
      a_q       <= a_d;
      b_q       <= b_d;
      len_q     <= len_d;
      cnt_q     <= cnt_d;
      wcnt_q    <= wcnt_d;
      busy      <= busy_d;
      finish    <= finish_d;
      mem_rwa   <= rwa_d;
      mem_rwb   <= rwb_d;
      mem_douta <= douta_d;
      mem_doutb <= doutb_d;
      mem_addra <= addra_d;
      mem_addrb <= addrb_d;
    end
  end

endmodule
